// File: rtl/vp_pkg.sv
// Shared definitions for the video-processing chain: data widths, RGB565
// field positions, the two RGB->YCbCr coefficient sets and small helpers.
package vp_pkg;

    localparam int PIX_W = 8;
    localparam int CNT_W = 11;

    // RGB565 field positions inside a 16-bit pixel
    localparam int R_MSB = 15;
    localparam int R_LSB = 11;
    localparam int G_MSB = 10;
    localparam int G_LSB = 5;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;

    // Coefficient magnitudes in row order Y(R,G,B), Cb(R,G,B), Cr(R,G,B);
    // signs are the same for both sets and live in COEF_NEG.
    typedef struct packed {
        logic [0:8][7:0] k;
        logic [17:0]     y_pre;   // offset added before the >>8
        logic [17:0]     c_pre;
        logic [7:0]      y_post;  // offset added after the >>8
        logic [7:0]      c_post;
        logic [7:0]      y_min;
        logic [7:0]      y_max;
        logic [7:0]      c_min;
        logic [7:0]      c_max;
    } coef_set_t;

    localparam logic [0:8] COEF_NEG = 9'b000_110_011;

    localparam coef_set_t COEF_FULL = '{
        k:      {8'd77, 8'd150, 8'd29, 8'd43, 8'd85, 8'd128, 8'd128, 8'd107, 8'd21},
        y_pre:  18'd0,
        c_pre:  18'd32768,
        y_post: 8'd0,
        c_post: 8'd0,
        y_min:  8'd0,
        y_max:  8'd255,
        c_min:  8'd0,
        c_max:  8'd255
    };

    localparam coef_set_t COEF_LIMITED = '{
        k:      {8'd66, 8'd129, 8'd25, 8'd38, 8'd74, 8'd112, 8'd112, 8'd94, 8'd18},
        y_pre:  18'd128,
        c_pre:  18'd128,
        y_post: 8'd16,
        c_post: 8'd128,
        y_min:  8'd16,
        y_max:  8'd235,
        c_min:  8'd16,
        c_max:  8'd240
    };

    // Apply the sign of one product term in the 18-bit signed sum domain
    function automatic logic signed [17:0] signed_term(logic [15:0] p, logic neg);
        logic signed [17:0] t;
        t = $signed({2'b00, p});
        return neg ? -t : t;
    endfunction

    // Arithmetic >>8, add the post offset, clamp into [lo,hi]
    function automatic logic [7:0] clamp_pix(logic [17:0] sum, logic [7:0] post,
                                             logic [7:0] lo, logic [7:0] hi);
        logic signed [17:0] sh;
        logic signed [17:0] v;
        logic [7:0]         res;
        sh = $signed(sum) >>> 8;
        v  = sh + $signed({10'd0, post});
        if (v < $signed({10'd0, lo}))
            res = lo;
        else if (v > $signed({10'd0, hi}))
            res = hi;
        else
            res = v[7:0];
        return res;
    endfunction

    // Counter increment that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rgb565_ycbcr_if.sv
// Pixel stream bundle: camera-side RGB565 input and YCbCr output with
// frame timing, position tags and the per-frame error flag.
interface rgb565_ycbcr_if;
    import vp_pkg::*;

    logic             per_frame_vsync;
    logic             per_frame_href;
    logic             per_frame_clken;
    logic [15:0]      per_rgb;

    logic             post_frame_vsync;
    logic             post_frame_href;
    logic             post_frame_clken;
    logic [PIX_W-1:0] post_y;
    logic [PIX_W-1:0] post_cb;
    logic [PIX_W-1:0] post_cr;
    logic [CNT_W-1:0] post_hcnt;
    logic [CNT_W-1:0] post_vcnt;
    logic             frame_err;

    // Source side (camera / bench)
    modport master (
        output per_frame_vsync, per_frame_href, per_frame_clken, per_rgb,
        input  post_frame_vsync, post_frame_href, post_frame_clken,
               post_y, post_cb, post_cr, post_hcnt, post_vcnt, frame_err
    );

    // Converter side
    modport slave (
        input  per_frame_vsync, per_frame_href, per_frame_clken, per_rgb,
        output post_frame_vsync, post_frame_href, post_frame_clken,
               post_y, post_cb, post_cr, post_hcnt, post_vcnt, frame_err
    );

endinterface

// File: rtl/vp_sync_delay.sv
// Fixed-depth shift register for frame timing and position tags, so they
// stay aligned with a DEPTH-stage data pipeline.
module vp_sync_delay #(
    parameter int DEPTH = 3,
    parameter int W     = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] stage_reg [DEPTH];

    // Shift every clock; reset flushes all stages so nothing in flight survives
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                stage_reg[i] <= '0;
        end else begin
            stage_reg[0] <= din;
            for (int i = 1; i < DEPTH; i++)
                stage_reg[i] <= stage_reg[i-1];
        end
    end

    assign dout = stage_reg[DEPTH-1];

endmodule

// File: rtl/rgb565_ycbcr.sv
// RGB565 -> YCbCr 8-bit converter, 3-clock free-running pipeline, with
// input-side pixel/line counters and a sticky malformed-frame flag.
// Build option: define YCBCR_LIMITED_RANGE_EN for BT.601 studio swing;
// full-range conversion otherwise.
module rgb565_ycbcr
    import vp_pkg::*;
#(
    parameter logic [CNT_W-1:0] IMG_HDISP = 11'd1280,
    parameter logic [CNT_W-1:0] IMG_VDISP = 11'd720
) (
    input  logic          clk,
    input  logic          rst,
    rgb565_ycbcr_if.slave vif
);

`ifdef YCBCR_LIMITED_RANGE_EN
    localparam coef_set_t COEF = COEF_LIMITED;
`else
    localparam coef_set_t COEF = COEF_FULL;
`endif

    localparam int TAG_W = 4 + 2 * CNT_W;

    // ---------------- colour datapath ----------------
    logic [4:0]         r5, b5;
    logic [5:0]         g6;
    logic [7:0]         chan [3];
    logic [15:0]        prod_next [9];
    logic [15:0]        prod_reg  [9];
    logic signed [17:0] sum_next  [3];
    logic signed [17:0] sum_reg   [3];
    logic [7:0]         pix_next  [3];
    logic [7:0]         pix_reg   [3];

    assign r5 = vif.per_rgb[R_MSB:R_LSB];
    assign g6 = vif.per_rgb[G_MSB:G_LSB];
    assign b5 = vif.per_rgb[B_MSB:B_LSB];

    // Replicate the top bits so full-scale 5/6-bit codes map to 255
    assign chan[0] = {r5, r5[4:2]};
    assign chan[1] = {g6, g6[5:4]};
    assign chan[2] = {b5, b5[4:2]};

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_mul
            assign prod_next[gi] = 16'(COEF.k[gi]) * 16'(chan[gi % 3]);
        end
        for (gi = 0; gi < 3; gi++) begin : g_chan
            localparam logic [17:0] PRE  = (gi == 0) ? COEF.y_pre  : COEF.c_pre;
            localparam logic [7:0]  POST = (gi == 0) ? COEF.y_post : COEF.c_post;
            localparam logic [7:0]  LO   = (gi == 0) ? COEF.y_min  : COEF.c_min;
            localparam logic [7:0]  HI   = (gi == 0) ? COEF.y_max  : COEF.c_max;
            assign sum_next[gi] = $signed(PRE)
                                + signed_term(prod_reg[3*gi],   COEF_NEG[3*gi])
                                + signed_term(prod_reg[3*gi+1], COEF_NEG[3*gi+1])
                                + signed_term(prod_reg[3*gi+2], COEF_NEG[3*gi+2]);
            assign pix_next[gi] = clamp_pix(sum_reg[gi], POST, LO, HI);
        end
    endgenerate

    // Three pipeline stages: products, signed sums, shifted/clamped pixels
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 9; i++)
                prod_reg[i] <= '0;
            for (int i = 0; i < 3; i++) begin
                sum_reg[i] <= '0;
                pix_reg[i] <= (i == 0) ? 8'd0 : 8'd128;
            end
        end else begin
            for (int i = 0; i < 9; i++)
                prod_reg[i] <= prod_next[i];
            for (int i = 0; i < 3; i++) begin
                sum_reg[i] <= sum_next[i];
                pix_reg[i] <= pix_next[i];
            end
        end
    end

    // ---------------- timing, counters, error ----------------
    // The armed flags make edge detection wait until the sync has been seen
    // low after reset, so a reset mid-line or mid-frame cannot fake an edge.
    logic             href_prev_reg, vsync_prev_reg;
    logic             href_armed_reg, vsync_armed_reg;
    logic             seen_vsync_reg;
    logic [CNT_W-1:0] hcnt_reg, hcnt_next;
    logic [CNT_W-1:0] vcnt_reg, vcnt_next;
    logic [CNT_W-1:0] lines_seen;
    logic [CNT_W-1:0] hcnt_tag, vcnt_tag;
    logic             err_reg, err_next, err_set;
    logic             href_rise, href_fall, vsync_rise;
    logic [TAG_W-1:0] tag_in, tag_out;

    assign href_rise  =  vif.per_frame_href  & ~href_prev_reg  & href_armed_reg;
    assign href_fall  = ~vif.per_frame_href  &  href_prev_reg  & href_armed_reg;
    assign vsync_rise =  vif.per_frame_vsync & ~vsync_prev_reg & vsync_armed_reg;

    // Next counter/error state and the position tag of the current input pixel
    always_comb begin
        hcnt_next = hcnt_reg;
        if (href_rise)
            hcnt_next = vif.per_frame_clken ? CNT_W'(1) : '0;
        else if (vif.per_frame_href && vif.per_frame_clken && href_armed_reg)
            hcnt_next = sat_inc(hcnt_reg);

        lines_seen = href_fall ? sat_inc(vcnt_reg) : vcnt_reg;
        vcnt_next  = vsync_rise ? '0 : lines_seen;

        hcnt_tag = href_rise  ? '0 : hcnt_reg;
        vcnt_tag = vsync_rise ? '0 : vcnt_reg;

        err_set  = (href_fall && (hcnt_reg != IMG_HDISP))
                 || (vsync_rise && seen_vsync_reg
                     && (lines_seen != IMG_VDISP) && (lines_seen != '0));
        err_next = err_set | (err_reg & ~vsync_rise);
    end

    // Input-side counter and edge-detect state
    always_ff @(posedge clk) begin
        if (rst) begin
            href_prev_reg   <= 1'b0;
            vsync_prev_reg  <= 1'b0;
            href_armed_reg  <= 1'b0;
            vsync_armed_reg <= 1'b0;
            seen_vsync_reg  <= 1'b0;
            hcnt_reg        <= '0;
            vcnt_reg        <= '0;
            err_reg         <= 1'b0;
        end else begin
            href_prev_reg   <= vif.per_frame_href;
            vsync_prev_reg  <= vif.per_frame_vsync;
            href_armed_reg  <= href_armed_reg  | ~vif.per_frame_href;
            vsync_armed_reg <= vsync_armed_reg | ~vif.per_frame_vsync;
            seen_vsync_reg  <= seen_vsync_reg  | vsync_rise;
            hcnt_reg        <= hcnt_next;
            vcnt_reg        <= vcnt_next;
            err_reg         <= err_next;
        end
    end

    // err_next enters the delay line so the flag lands with the event's syncs
    assign tag_in = {vif.per_frame_vsync, vif.per_frame_href, vif.per_frame_clken,
                     err_next, hcnt_tag, vcnt_tag};

    vp_sync_delay #(
        .DEPTH (3),
        .W     (TAG_W)
    ) u_sync_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (tag_in),
        .dout (tag_out)
    );

    assign {vif.post_frame_vsync, vif.post_frame_href, vif.post_frame_clken,
            vif.frame_err, vif.post_hcnt, vif.post_vcnt} = tag_out;

    assign vif.post_y  = pix_reg[0];
    assign vif.post_cb = pix_reg[1];
    assign vif.post_cr = pix_reg[2];

endmodule

// File: doc/rgb565_ycbcr.md
Name: rgb565_ycbcr

Overview:
- Colour-space front end of the DVP video-processing chain.
- Converts camera RGB565 pixels into 8-bit Y, Cb and Cr, with a fixed 3-clock pipeline.
- Feeds the per_y / per_Cb / per_Cr inputs of the 3x3 median filter.
- Also carries frame timing through, produces pixel/line position counters, and flags frames with malformed line lengths.

Parameters:
- IMG_HDISP, 11'd1280, active pixels per line; used for the line-length check.
- IMG_VDISP, 11'd720, active lines per frame; used for the line-count check.

Ports:
- clk  in  1  cmos video pixel clock.
- rst  in  1  one clock; reset is synchronous and active-high.
- per_frame_vsync  in  1  input frame sync.
- per_frame_href  in  1  input line valid.
- per_frame_clken  in  1  input pixel strobe.
- per_rgb  in  16  pixel, {R[4:0],G[5:0],B[4:0]}.
- post_frame_vsync  out  1  vsync delayed 3 clk.
- post_frame_href  out  1  href delayed 3 clk.
- post_frame_clken  out  1  clken delayed 3 clk.
- post_y  out  8  luma.
- post_cb  out  8  blue-difference chroma.
- post_cr  out  8  red-difference chroma.
- post_hcnt  out  11  column index of the pixel on post_y.
- post_vcnt  out  11  line index of the pixel on post_y.
- frame_err  out  1  sticky error for the current frame.

Behaviour:
- Reset (rst=1 at posedge): all pipeline registers, outputs, counters and frame_err go to 0. Exception: post_cb/post_cr reset to 8'd128 (neutral chroma). A reset mid-frame drops in-flight pixels; nothing is emitted until the next valid clken.
- Pipeline is free-running, advancing every clk (not gated by clken). Syncs are delayed through a 3-deep shift register, so data and post_frame_clken stay aligned regardless of clken gaps.
- Expansion (combinational into stage 1):
  - R8={R5,R5[4:2]}
  - G8={G6,G6[5:4]}
  - B8={B5,B5[4:2]}
- Stage 1: register nine 16-bit products, coefficient x channel.
- Stage 2: signed 18-bit sums, including offsets.
- Stage 3: arithmetic shift right by 8, saturate to [0,255], register the outputs.
- Full-range coefficients (default):
  - Y = (77R + 150G + 29B) >> 8
  - Cb = (-43R - 85G + 128B + 32768) >> 8
  - Cr = (128R - 107G - 21B + 32768) >> 8
- Input-side counters, tagged onto the pipeline alongside the data:
  - hcnt: cleared on the href rising edge; increments on each clken while href=1.
  - vcnt: cleared on the vsync rising edge; increments on each href falling edge.
  - If clken and the href rising edge coincide, that pixel is column 0.
  - Counters saturate at 2047; no wrap.
- frame_err:
  - Sets on an href falling edge when the pixel count on that line is not IMG_HDISP.
  - Sets on a vsync rising edge when the previous frame's line count is not IMG_VDISP and is nonzero. The first frame after reset is exempt.
  - Clears on the vsync rising edge; if a set and a clear coincide, set wins.
  - Visible 3 clk after the causing event, aligned with the post_* syncs.

Optional Feature:
- Macro: YCBCR_LIMITED_RANGE_EN.
- Defined (BT.601 studio swing):
  - Y = ((66R + 129G + 25B + 128) >>> 8) + 16
  - Cb = ((-38R - 74G + 112B + 128) >>> 8) + 128
  - Cr = ((112R - 94G - 18B + 128) >>> 8) + 128
  - Y is clamped to [16,235]; Cb/Cr to [16,240].
- Undefined: the full-range equations above.
- Latency is unchanged in both builds.

Decomposition:
- Shared package vp_pkg holds:
  - PIX_W=8, CNT_W=11.
  - Both coefficient sets as localparams.
  - The RGB565 field bit positions.
- One sub-module, vp_sync_delay: a parameterised-depth shift register for vsync/href/clken/hcnt/vcnt. It is reused by later VP stages.

Test Plan:
- White: per_rgb=16'hFFFF, clken=1 -> 3 clk later Y=255, Cb=128, Cr=128, post_frame_clken=1.
- Black then red: 16'h0000 -> Y=0, Cb=128, Cr=128. Then 16'hF800 -> Y=76, Cb=85, Cr=255.
- Blue with clken gaps: 16'h001F with clken toggling 1,0,1 -> Y=28, Cb=255, Cr=107. Output clken shows the same 1,0,1 pattern exactly 3 clk later.
- Timing: 1280-pixel lines x 720 lines -> frame_err stays 0; post_hcnt runs 0..1279; post_vcnt runs 0..719. A 1279-pixel line -> frame_err=1, cleared at the next vsync rise.
- Reset mid-line at pixel 600: -> all outputs return to reset values the next clk. The next line restarts hcnt at 0 with no spurious clken.
- YCBCR_LIMITED_RANGE_EN build: 16'hFFFF -> Y=235, Cb=128, Cr=128. 16'h0000 -> Y=16, Cb=128, Cr=128.
